// File: rtl/d7s_pkg.sv
// Shared constants for the 3-digit 7-segment scan controller:
// segment glyphs {a,b,c,d,e,f,g}, FSM state type and counter sizing helper.
package d7s_pkg;

   localparam int NUM_DIGITS = 3;

   localparam logic [6:0] SEG_0    = 7'b1111110;
   localparam logic [6:0] SEG_1    = 7'b0110000;
   localparam logic [6:0] SEG_2    = 7'b1101101;
   localparam logic [6:0] SEG_3    = 7'b1111001;
   localparam logic [6:0] SEG_4    = 7'b0110011;
   localparam logic [6:0] SEG_5    = 7'b1011011;
   localparam logic [6:0] SEG_6    = 7'b1011111;
   localparam logic [6:0] SEG_7    = 7'b1110000;
   localparam logic [6:0] SEG_8    = 7'b1111111;
   localparam logic [6:0] SEG_9    = 7'b1111011;
   localparam logic [6:0] SEG_DASH = 7'b0000001;
   localparam logic [6:0] SEG_OFF  = 7'b0000000;

   typedef enum logic {
      S_BLANK = 1'b0,
      S_ON    = 1'b1
   } state_t;

   // Phase counter width; clamped to 1 bit so single-cycle phases still get a counter.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder, active-high segments {a..g}.
// Codes A-F render as a dash.
module bcd_to_7seg
   import d7s_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_DASH;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/d7s_scan_ctrl.sv
// 3-digit multiplexed 7-segment scanner with blanking gaps and frame-aligned value commit.
// Optional D7S_LEADING_ZERO_BLANK_EN suppresses leading zeros on d2/d1.
module d7s_scan_ctrl
   import d7s_pkg::*;
#(
   parameter int ON_CYCLES    = 1000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_valid,
   input  logic [11:0] load_bcd,
   output logic        load_ready,
   output logic [2:0]  transistor,
   output logic [6:0]  d7sp,
   output logic        frame_tick
);

   localparam int CW = cnt_width(ON_CYCLES, BLANK_CYCLES);
   localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

   state_t                         state_q, state_d;
   logic [1:0]                     dig_q, dig_d;
   logic [CW-1:0]                  cnt_q, cnt_d;
   logic [NUM_DIGITS-1:0][3:0]     active_q, shadow_q;
   logic                           pending_q, pending_d;
   logic                           load_ready_q;
   logic [2:0]                     transistor_q, transistor_d;
   logic [6:0]                     d7sp_q, d7sp_d;
   logic                           frame_tick_q, frame_tick_d;
   logic                           take, commit, boundary, lz_blank;
   logic [6:0]                     seg_dec;

   bcd_to_7seg u_dec (
      .bcd_i (active_q[dig_q]),
      .seg_o (seg_dec)
   );

`ifdef D7S_LEADING_ZERO_BLANK_EN
   assign lz_blank = ((dig_q == 2'd2) && (active_q[2] == 4'd0)) ||
                     ((dig_q == 2'd1) && (active_q[2] == 4'd0) && (active_q[1] == 4'd0));
`else
   assign lz_blank = 1'b0;
`endif

   assign boundary = (state_q == S_ON) && (dig_q == 2'd2) && (cnt_q == ON_LAST);
   assign take     = load_valid && load_ready_q;
   assign commit   = boundary && pending_q;

   always_comb begin
      state_d = state_q;
      dig_d   = dig_q;
      cnt_d   = cnt_q + CW'(1);
      case (state_q)
         S_BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               state_d = S_ON;
               cnt_d   = '0;
            end
         end
         default: begin
            if (cnt_q == ON_LAST) begin
               state_d = S_BLANK;
               cnt_d   = '0;
               dig_d   = (dig_q == 2'd2) ? 2'd0 : dig_q + 2'd1;
            end
         end
      endcase

      // A take and a commit cannot coincide: load_ready is low whenever pending is set.
      pending_d = pending_q;
      if (take)
         pending_d = 1'b1;
      else if (commit)
         pending_d = 1'b0;

      // Digit only changes on ON->BLANK, so dig_q already selects the digit being entered.
      transistor_d = (state_d == S_ON) ? (3'b001 << dig_d) : 3'b000;
      d7sp_d       = ((state_d == S_ON) && !lz_blank) ? seg_dec : SEG_OFF;
      frame_tick_d = (state_d == S_ON) && (dig_d == 2'd2) && (cnt_d == ON_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_BLANK;
         dig_q        <= 2'd0;
         cnt_q        <= '0;
         active_q     <= '0;
         shadow_q     <= '0;
         pending_q    <= 1'b0;
         load_ready_q <= 1'b1;
         transistor_q <= 3'b000;
         d7sp_q       <= SEG_OFF;
         frame_tick_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         dig_q        <= dig_d;
         cnt_q        <= cnt_d;
         if (take)
            shadow_q <= load_bcd;
         if (commit)
            active_q <= shadow_q;
         pending_q    <= pending_d;
         load_ready_q <= ~pending_d;
         transistor_q <= transistor_d;
         d7sp_q       <= d7sp_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign load_ready = load_ready_q;
   assign transistor = transistor_q;
   assign d7sp       = d7sp_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_d7s_scan_ctrl.sv
// Bench for d7s_scan_ctrl (ON=4, BLANK=2): frame-position reference model, directed
// scenarios with literal expectations, and a randomized load phase.
module tb_d7s_scan_ctrl;

   localparam int ON    = 4;
   localparam int BLANK = 2;
   localparam int SLOT  = ON + BLANK;
   localparam int FRAME = 3 * SLOT;

   logic        clk;
   logic        rst;
   logic        load_valid;
   logic [11:0] load_bcd;
   logic        load_ready;
   logic [2:0]  transistor;
   logic [6:0]  d7sp;
   logic        frame_tick;

   int n_checks = 0;
   int n_pass   = 0;

   d7s_scan_ctrl #(.ON_CYCLES(ON), .BLANK_CYCLES(BLANK)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_bcd   (load_bcd),
      .load_ready (load_ready),
      .transistor (transistor),
      .d7sp       (d7sp),
      .frame_tick (frame_tick)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'd0: return 7'b1111110;
         4'd1: return 7'b0110000;
         4'd2: return 7'b1101101;
         4'd3: return 7'b1111001;
         4'd4: return 7'b0110011;
         4'd5: return 7'b1011011;
         4'd6: return 7'b1011111;
         4'd7: return 7'b1110000;
         4'd8: return 7'b1111111;
         4'd9: return 7'b1111011;
         default: return 7'b0000001;
      endcase
   endfunction

   function automatic logic [6:0] seg_of(input int d, input logic [11:0] a);
`ifdef D7S_LEADING_ZERO_BLANK_EN
      if (d == 2 && a[11:8] == 4'd0) return 7'b0000000;
      if (d == 1 && a[11:4] == 8'd0) return 7'b0000000;
`endif
      return glyph(a[d*4 +: 4]);
   endfunction

   // Reference model: cycles since reset release plus committed/shadow value.
   int          t;
   logic [11:0] m_active, m_shadow;
   bit          m_pending, m_was_pending, model_valid;

   initial model_valid = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         t = 0; m_active = 12'h000; m_shadow = 12'h000; m_pending = 1'b0; model_valid = 1'b1;
      end else if (model_valid) begin
         m_was_pending = m_pending;
         if ((t % FRAME) == FRAME - 1 && m_was_pending) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
         end
         if (load_valid && !m_was_pending) begin
            m_shadow  = load_bcd;
            m_pending = 1'b1;
         end
         t++;
      end
   end

   int          pos, dgt;
   bit          on;
   always @(negedge clk) begin
      if (model_valid) begin
         pos = t % FRAME;
         dgt = pos / SLOT;
         on  = (pos % SLOT) >= BLANK;
         chk("model_transistor", transistor, on ? (32'd1 << dgt) : 32'd0);
         chk("model_d7sp", d7sp, on ? seg_of(dgt, m_active) : 7'd0);
         chk("model_frame_tick", frame_tick, (pos == FRAME - 1) ? 1 : 0);
         chk("model_load_ready", load_ready, m_pending ? 0 : 1);
      end
   end

   // Enable-gap monitor used over the randomized frames.
   bit         gap_en = 1'b0;
   int         zcnt;
   logic [2:0] last_on, prev_tr;
   always @(negedge clk) begin
      if (gap_en) begin
         chk("onehot", ($countones(transistor) <= 1) ? 1 : 0, 1);
         if (transistor == 3'b000)
            zcnt++;
         else begin
            if (prev_tr == 3'b000 && last_on != 3'b000)
               chk("enable_gap", zcnt, BLANK);
            zcnt    = 0;
            last_on = transistor;
         end
         prev_tr = transistor;
      end
   end

   task automatic wait_tick();
      bit seen = 1'b0;
      for (int k = 0; k < 3 * FRAME && !seen; k++) begin
         @(negedge clk);
         seen = frame_tick;
      end
      if (!seen) chk("frame_tick_timeout", 0, 1);
   endtask

   task automatic capture(output logic [6:0] s0, output logic [6:0] s1, output logic [6:0] s2);
      s0 = 7'h7f; s1 = 7'h7f; s2 = 7'h7f;
      for (int k = 0; k < FRAME; k++) begin
         @(negedge clk);
         if (transistor == 3'b001) s0 = d7sp;
         if (transistor == 3'b010) s1 = d7sp;
         if (transistor == 3'b100) s2 = d7sp;
      end
   endtask

   task automatic load(input logic [11:0] v);
      @(posedge clk); #1;
      load_valid = 1'b1; load_bcd = v;
      @(posedge clk); #1;
      load_valid = 1'b0;
   endtask

   logic [6:0] s0, s1, s2;
   logic [6:0] lz_off_zero;
   bit         found;

   initial begin
`ifdef D7S_LEADING_ZERO_BLANK_EN
      lz_off_zero = 7'b0000000;
`else
      lz_off_zero = 7'b1111110;
`endif
      rst = 1'b1; load_valid = 1'b0; load_bcd = 12'h000;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset release: two blank cycles then digit 0 shows '0'.
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k < BLANK) chk("rel_blank", transistor, 3'b000);
         else begin
            chk("rel_d0_tr", transistor, 3'b001);
            chk("rel_d0_seg", d7sp, 7'b1111110);
         end
         chk("rel_ready", load_ready, 1);
         $display("reset-release cycle %0d: transistor=%b d7sp=%b ready=%b", k, transistor, d7sp, load_ready);
      end

      // Load 0x482, then offer 0x999 while pending.
      @(posedge clk); #1;
      load_valid = 1'b1; load_bcd = 12'h482;
      @(posedge clk); #1;
      load_bcd = 12'h999;
      @(negedge clk);
      chk("load_ready_drop", load_ready, 0);
      repeat (3) @(posedge clk);
      #1 load_valid = 1'b0;
      wait_tick();
      chk("tick_pending_ready", load_ready, 0);
      @(negedge clk);
      chk("ready_return", load_ready, 1);
      capture(s0, s1, s2);
      chk("v482_d0", s0, 7'b1101101);
      chk("v482_d1", s1, 7'b1111111);
      chk("v482_d2", s2, 7'b0110011);
      $display("load 0x482 (0x999 ignored): d0=%b d1=%b d2=%b", s0, s1, s2);

      // Load 0x0A7: dash on d1, d2 zero possibly suppressed.
      load(12'h0A7);
      wait_tick();
      @(negedge clk);
      capture(s0, s1, s2);
      chk("v0a7_d0", s0, 7'b1110000);
      chk("v0a7_d1", s1, 7'b0000001);
      chk("v0a7_d2", s2, lz_off_zero);
      $display("load 0x0A7: d0=%b d1=%b d2=%b", s0, s1, s2);

      // Reset during digit-1 ON with a pending load.
      wait_tick();
      load(12'h123);
      found = 1'b0;
      for (int k = 0; k < FRAME && !found; k++) begin
         @(negedge clk);
         found = (transistor == 3'b010);
      end
      if (!found) chk("dig1_timeout", 0, 1);
      chk("pending_before_rst", load_ready, 0);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_tr", transistor, 3'b000);
      chk("mid_rst_seg", d7sp, 7'b0000000);
      chk("mid_rst_ready", load_ready, 1);
      chk("mid_rst_tick", frame_tick, 0);
      capture(s0, s1, s2);
      chk("after_rst_d0", s0, 7'b1111110);
      chk("after_rst_d1", s1, lz_off_zero);
      chk("after_rst_d2", s2, lz_off_zero);
      $display("mid-frame reset: d0=%b d1=%b d2=%b", s0, s1, s2);

      // Randomized loads over 10+ frames with gap monitoring.
      zcnt = 0; last_on = 3'b000; prev_tr = 3'b000;
      gap_en = 1'b1;
      for (int k = 0; k < 11 * FRAME; k++) begin
         @(posedge clk); #1;
         load_valid = ($urandom_range(0, 3) == 0);
         load_bcd   = 12'($urandom_range(0, 4095));
      end
      #1 load_valid = 1'b0;
      repeat (FRAME) @(negedge clk);
      gap_en = 1'b0;
      $display("random phase done: %0d cycles", 11 * FRAME);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
